barrel_rotate_amount_finder: RTL and testbench

Inverse partner of the multi-direction barrel rotator. Given an original word, a rotated word and a direction, it finds the rotate amount that maps one onto the other. It does this by iterative one-bit rotation and compare, with a start/done handshake. Used as a self-check and recovery block beside the rotator datapath and in rotator regression benches.

---
 rtl/barrel_rotate_amount_finder_pkg.sv | 18 +
 rtl/barrel_rotate_amount_finder_if.sv | 36 +++
 rtl/barrel_rotate_amount_finder_rotate_by_one.sv | 29 ++
 rtl/barrel_rotate_amount_finder.sv | 109 ++++++++++
 tb/tb_barrel_rotate_amount_finder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_rotate_amount_finder_pkg.sv
// ---------------------------------------------------------------------------
// barrel_pkg
// Constants and types shared by the barrel rotator family. The direction
// encodings are the same ones the rotator and its bench use, so a direction
// bit can be passed between the blocks unchanged.
// ---------------------------------------------------------------------------
package barrel_pkg;

   localparam logic ROTATE_LEFT  = 1'b0;
   localparam logic ROTATE_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/barrel_rotate_amount_finder_if.sv
// ---------------------------------------------------------------------------
// barrel_rotate_amount_finder_if
// Request/result bundle of the rotate-amount finder.
//   start   : request strobe, honoured only while the finder is idle
//   data    : original (unrotated) word
//   rotated : rotated word to match against
//   dir_lr  : ROTATE_LEFT / ROTATE_RIGHT
//   busy    : search in progress
//   done    : one-cycle result strobe
//   found   : a matching amount exists
//   amt     : smallest matching amount (0 when not found)
// master = requester, slave = finder.
// ---------------------------------------------------------------------------
interface barrel_rotate_amount_finder_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
);
   logic             start;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] rotated;
   logic             dir_lr;
   logic             busy;
   logic             done;
   logic             found;
   logic [AMT_W-1:0] amt;

   modport master (
      output start, data, rotated, dir_lr,
      input  busy, done, found, amt
   );

   modport slave (
      input  start, data, rotated, dir_lr,
      output busy, done, found, amt
   );
endinterface

// File: rtl/barrel_rotate_amount_finder_rotate_by_one.sv
// ---------------------------------------------------------------------------
// rotate_by_one
// Combinational single-bit rotate in either direction.
//   i_data : word to rotate
//   i_dir  : ROTATE_LEFT / ROTATE_RIGHT
//   o_data : i_data rotated by one position
// ---------------------------------------------------------------------------
module rotate_by_one
   import barrel_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_data
);

   // One-position rotate; the MSB wraps to bit 0 on a left rotate and
   // bit 0 wraps to the MSB on a right rotate.
   always_comb begin
      o_data = i_data;
      case (i_dir)
         ROTATE_LEFT:  o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
         ROTATE_RIGHT: o_data = {i_data[0], i_data[WIDTH-1:1]};
         default:      o_data = i_data;
      endcase
   end

endmodule

// File: rtl/barrel_rotate_amount_finder.sv
// ---------------------------------------------------------------------------
// barrel_rotate_amount_finder
// Finds the smallest amount by which `data` must be rotated in direction
// `dir_lr` to equal `rotated`. The candidate is rotated one bit per cycle
// and compared against the target, so an amount k is reported k+1 cycles
// after the request and a miss after WIDTH cycles.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any search
//   bus   : request/result bundle (slave side)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module barrel_rotate_amount_finder
   import barrel_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   barrel_rotate_amount_finder_if.slave  bus
);

   state_t           r_state;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_tgt;
   logic             r_dir;
   logic [AMT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_found;
   logic [AMT_W-1:0] r_amt;
   logic [WIDTH-1:0] w_cand_next;

   rotate_by_one #(.WIDTH(WIDTH)) u_rot (
      .i_data (r_cand),
      .i_dir  (r_dir),
      .o_data (w_cand_next)
   );

   // Search controller: accepts a request in IDLE, steps the candidate in
   // SEARCH until it matches or every amount has been tried, then spends
   // one cycle in DONE presenting the result strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cand  <= '0;
         r_tgt   <= '0;
         r_dir   <= ROTATE_LEFT;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_found <= 1'b0;
         r_amt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_cand  <= bus.data;
                  r_tgt   <= bus.rotated;
                  r_dir   <= bus.dir_lr;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_found <= 1'b0;
                  r_amt   <= '0;
                  r_state <= SEARCH;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            SEARCH: begin
               // The compare runs before the rotate, so the first amount
               // tried is 0 and the smallest amount is always the one found.
               if (r_cand == r_tgt) begin
                  r_found <= 1'b1;
                  r_amt   <= r_cnt;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (r_cnt == AMT_W'(WIDTH - 1)) begin
                  r_found <= 1'b0;
                  r_amt   <= '0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cand  <= w_cand_next;
                  r_cnt   <= r_cnt + AMT_W'(1);
               end
            end
            DONE: begin
               // Result stays on found/amt; start is not looked at here.
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.found = r_found;
   assign bus.amt   = r_amt;

endmodule

// File: tb/tb_barrel_rotate_amount_finder.sv
// ---------------------------------------------------------------------------
// tb_barrel_rotate_amount_finder
// Scoreboard bench: the driver pushes the reference result of every accepted
// request; a monitor pops and compares on each done strobe.
// ---------------------------------------------------------------------------
module tb_barrel_rotate_amount_finder;
   import barrel_pkg::*;

   localparam int W  = 8;
   localparam int AW = $clog2(W);

   typedef struct {
      logic found;
      int   amt;
      int   lat;
      int   t0;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   errors;
   int   checks;
   exp_t sb_q[$];

   barrel_rotate_amount_finder_if #(.WIDTH(W)) bus ();

   barrel_rotate_amount_finder #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference rotate by an arbitrary amount, written as a shift pair.
   function automatic logic [W-1:0] rot(input logic [W-1:0] d, input int a, input logic dir);
      logic [2*W-1:0] dd;
      if (a % W == 0) return d;
      dd = {d, d};
      if (dir == ROTATE_LEFT) return dd[(2*W - (a % W)) - 1 -: W];
      else                    return dd[(a % W) +: W];
   endfunction

   // Reference: smallest amount whose rotation of d equals r.
   function automatic void model(input logic [W-1:0] d, input logic [W-1:0] r,
                                 input logic dir, output logic f, output int a);
      f = 1'b0;
      a = 0;
      for (int k = 0; k < W; k++) begin
         if (!f && rot(d, k, dir) == r) begin
            f = 1'b1;
            a = k;
         end
      end
   endfunction

   // Monitor: compares each done strobe with the oldest expectation and
   // checks busy has dropped on the following cycle.
   initial begin
      exp_t e;
      logic busy_chk;
      busy_chk = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_chk) begin
            check("busy_after_done", int'(bus.busy), 0);
            busy_chk = 1'b0;
         end
         if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               check("found", int'(bus.found), int'(e.found));
               check("amt", int'(bus.amt), e.amt);
               check("latency", cyc - e.t0, e.lat);
               busy_chk = 1'b1;
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("idle_timeout", 1, 0);
   endtask

   task automatic launch(input logic [W-1:0] d, input logic [W-1:0] r, input logic dir);
      exp_t e;
      logic f;
      int   a;
      model(d, r, dir, f, a);
      e.found = f;
      e.amt   = a;
      e.lat   = f ? a + 1 : W;
      e.t0    = cyc + 1;
      bus.start   = 1'b1;
      bus.data    = d;
      bus.rotated = r;
      bus.dir_lr  = dir;
      sb_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < W + 6) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check("done_timeout", 1, 0);
         sb_q.delete();
      end
   endtask

   task automatic run(input logic [W-1:0] d, input logic [W-1:0] r, input logic dir);
      wait_idle();
      launch(d, r, dir);
      wait_done();
   endtask

   initial begin
      logic [W-1:0] d;
      logic         dir;
      int           a;
      errors = 0;
      checks = 0;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.data    = '0;
      bus.rotated = '0;
      bus.dir_lr  = ROTATE_LEFT;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy",  int'(bus.busy),  0);
      check("rst_done",  int'(bus.done),  0);
      check("rst_found", int'(bus.found), 0);
      check("rst_amt",   int'(bus.amt),   0);

      // Directed cases from the plan.
      run(8'b0000_0001, 8'b0000_1000, ROTATE_LEFT);
      check("left_01_08_amt", int'(bus.amt), 3);
      run(8'b0000_0001, 8'b0010_0000, ROTATE_RIGHT);
      check("right_01_20_amt", int'(bus.amt), 3);
      run(8'b0000_0001, 8'b0010_0000, ROTATE_LEFT);
      check("left_01_20_amt", int'(bus.amt), 5);
      for (int k = 0; k < W; k++) begin
         run(8'b0000_0001, rot(8'b0000_0001, k, ROTATE_LEFT), ROTATE_LEFT);
         run(8'b0000_0001, rot(8'b0000_0001, k, ROTATE_RIGHT), ROTATE_RIGHT);
      end
      run(8'b0000_0011, 8'b0000_0101, ROTATE_LEFT);
      check("nomatch_found", int'(bus.found), 0);
      run(8'b1010_1010, 8'b0101_0101, ROTATE_LEFT);
      check("periodic_amt", int'(bus.amt), 1);
      run(8'b0000_0000, 8'b0000_0000, ROTATE_RIGHT);
      run(8'b1111_1111, 8'b1111_1110, ROTATE_LEFT);

      // start held during a search with other operands must be ignored.
      wait_idle();
      launch(8'b0000_0001, 8'b1000_0000, ROTATE_LEFT);
      for (int i = 0; i < 4; i++) begin
         bus.start   = 1'b1;
         bus.data    = 8'($urandom);
         bus.rotated = bus.data;
         bus.dir_lr  = ROTATE_RIGHT;
         @(negedge clk);
      end
      bus.start = 1'b0;
      wait_done();
      check("ignore_amt", int'(bus.amt), 7);
      repeat (3) @(negedge clk);

      // Reset three cycles into a search aborts it without a done strobe.
      wait_idle();
      launch(8'b0000_0011, 8'b0000_0101, ROTATE_LEFT);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      check("abort_busy",  int'(bus.busy),  0);
      check("abort_done",  int'(bus.done),  0);
      check("abort_found", int'(bus.found), 0);
      check("abort_amt",   int'(bus.amt),   0);
      repeat (W + 2) @(negedge clk);
      run(8'b0001_0000, 8'b0000_0100, ROTATE_RIGHT);
      check("post_reset_amt", int'(bus.amt), 2);

      // Random requests: about half are genuine rotations.
      for (int i = 0; i < 40; i++) begin
         d   = 8'($urandom);
         dir = 1'($urandom);
         a   = int'($urandom_range(W - 1, 0));
         if ($urandom_range(1, 0) == 1) run(d, rot(d, a, dir), dir);
         else                           run(d, 8'($urandom), dir);
      end

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
